// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and encodings for the audio frame buffer.
package audio_pkg;
    localparam int CH_LEFT   = 0;
    localparam int CH_RIGHT  = 1;
    localparam int CH_MONO   = 2;
    localparam int FFT_N_DEF = 1024;
    localparam int ADDR_W    = $clog2(FFT_N_DEF);

    typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_DRAINING} bank_st_e;
    typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_st_e;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: simple dual-port RAM, registered read with read enable.
module frame_buffer_ram #(
    parameter int WL = 16,
    parameter int AW = 11
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [WL-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [WL-1:0] o_rdata
);
    logic [WL-1:0] r_mem [2**AW];
    logic [WL-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: collects captured audio samples into ping-pong frames
// and streams each completed frame out over valid/ready.
module audio_frame_buffer
    import audio_pkg::*;
#(
    parameter int WL     = 16,
    parameter int FFT_N  = 1024,
    parameter int CH_SEL = CH_LEFT
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_adc_data,
    input  logic          i_rx_done,
    input  logic          i_enable,
    output logic [WL-1:0] o_m_tdata,
    output logic          o_m_tvalid,
    input  logic          i_m_tready,
    output logic          o_m_tlast,
    output logic [15:0]   o_frame_cnt,
    output logic          o_overrun
);
    localparam int AW = addr_w(FFT_N);
    localparam logic [AW-1:0] LAST = AW'(FFT_N - 1);

    logic [2:0]        r_sync;
    bank_st_e          r_bank [2];
    rd_st_e            r_state, w_next;
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr, w_rd_next;
    logic              r_rd_bank, r_first, r_overrun, r_we;
    logic [AW:0]       r_waddr, w_raddr;
    logic [WL-1:0]     r_wdata, w_rdata, w_sample;
    logic [15:0]       r_frame_cnt;
    logic signed [WL:0] w_sum;
    logic w_cap, w_has_fill, w_has_empty, w_wbank, w_wr_ok, w_drop, w_wr_last;
    logic w_full0, w_full1, w_any_full, w_pick, w_claim, w_hs, w_last, w_re;

    assign w_cap    = r_sync[1] & ~r_sync[2];
    assign w_sum    = $signed({i_adc_data[31], i_adc_data[31:16]}) + $signed({i_adc_data[15], i_adc_data[15:0]});
    assign w_sample = (CH_SEL == CH_MONO)  ? WL'(w_sum >>> 1) :
                      (CH_SEL == CH_RIGHT) ? i_adc_data[15:0] : i_adc_data[31:16];

    assign w_has_fill  = (r_bank[0] == BK_FILLING) || (r_bank[1] == BK_FILLING);
    assign w_has_empty = (r_bank[0] == BK_EMPTY) || (r_bank[1] == BK_EMPTY);
    assign w_wbank     = w_has_fill ? (r_bank[1] == BK_FILLING) : (r_bank[0] != BK_EMPTY);
    assign w_wr_ok     = w_cap & i_enable & (w_has_fill | w_has_empty);
    assign w_drop      = w_cap & i_enable & ~(w_has_fill | w_has_empty);
    assign w_wr_last   = r_wr_ptr == LAST;

    // r_first remembers which bank filled first when both are waiting
    assign w_full0    = r_bank[0] == BK_FULL;
    assign w_full1    = r_bank[1] == BK_FULL;
    assign w_any_full = w_full0 | w_full1;
    assign w_pick     = (w_full0 & w_full1) ? r_first : w_full1;
    assign w_hs       = (r_state == RD_STREAM) & i_m_tready;
    assign w_last     = w_hs & (r_rd_ptr == LAST);
    assign w_re       = (r_state == RD_PRIME) | w_hs;
    assign w_rd_next  = (r_state == RD_PRIME) ? {AW{1'b0}} : r_rd_ptr + 1'b1;
    assign w_raddr    = {r_rd_bank, w_rd_next};

    always_comb begin
        w_next  = r_state;
        w_claim = 1'b0;
        case (r_state)
            RD_IDLE: begin
                w_next  = w_any_full ? RD_PRIME : RD_IDLE;
                w_claim = w_any_full;
            end
            RD_PRIME: w_next = RD_STREAM;
            RD_STREAM: if (w_last) begin
                w_next  = w_any_full ? RD_PRIME : RD_IDLE;
                w_claim = w_any_full;
            end
            default: w_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= '0;
            r_state     <= RD_IDLE;
            r_bank[0]   <= BK_EMPTY;
            r_bank[1]   <= BK_EMPTY;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_bank   <= 1'b0;
            r_first     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_sync  <= {r_sync[1:0], i_rx_done};
            r_state <= w_next;
            r_we    <= w_wr_ok;
            r_waddr <= {w_wbank, r_wr_ptr};
            r_wdata <= w_sample;
            if (w_drop) r_overrun <= 1'b1;
            if (!i_enable) begin
                r_wr_ptr <= '0;
                for (int b = 0; b < 2; b++)
                    if (r_bank[b] == BK_FILLING) r_bank[b] <= BK_EMPTY;
            end else if (w_wr_ok) begin
                r_wr_ptr        <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
                r_bank[w_wbank] <= w_wr_last ? BK_FULL : BK_FILLING;
                if (w_wr_last) r_first <= (r_bank[~w_wbank] == BK_FULL) ? ~w_wbank : w_wbank;
            end
            if (w_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_last) begin
                r_bank[r_rd_bank] <= BK_EMPTY;
                r_frame_cnt       <= r_frame_cnt + 1'b1;
            end
            if (w_claim) begin
                r_bank[w_pick] <= BK_DRAINING;
                r_rd_bank      <= w_pick;
                r_rd_ptr       <= '0;
            end
        end
    end

    frame_buffer_ram #(.WL(WL), .AW(AW + 1)) u_ram (
        .i_clk   (i_clk),
        .i_we    (r_we),
        .i_waddr (r_waddr),
        .i_wdata (r_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign o_m_tvalid  = r_state == RD_STREAM;
    assign o_m_tlast   = o_m_tvalid & (r_rd_ptr == LAST);
    assign o_m_tdata   = o_m_tvalid ? w_rdata : '0;
    assign o_frame_cnt = r_frame_cnt;
    assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_audio_frame_buffer.sv
// tb_audio_frame_buffer: left-channel and mono instances checked against a
// frame-level queue model plus literal expectations.
module tb_audio_frame_buffer;
    import audio_pkg::*;
    localparam int N = 16;

    logic clk = 0, rst_n = 1, rx_done = 0, en = 0, rdy_fix = 0, rnd_rdy = 0, rbit = 0;
    logic ready;
    logic [31:0] adc = 0;
    logic [1:0] tv, tl, ov;
    logic [1:0][15:0] td, fc;
    int n_chk = 0, n_fail = 0;
    logic [15:0] q0[$], q1[$], p0[$], p1[$], log0[$], log1[$];
    int nfull = 0, sz;
    int idx[2], cnt[2];
    bit m_ovr = 0;
    bit gap[2], stall[2];
    logic [15:0] pd[2], hd;
    logic pl[2];

    always #5 clk = ~clk;
    always @(posedge clk) begin #1; rbit = 1'($urandom_range(0, 1)); end
    assign ready = rnd_rdy ? rbit : rdy_fix;

    audio_frame_buffer #(.WL(16), .FFT_N(N), .CH_SEL(CH_LEFT)) u_left (
        .i_clk(clk), .i_rst_n(rst_n), .i_adc_data(adc), .i_rx_done(rx_done), .i_enable(en),
        .o_m_tdata(td[0]), .o_m_tvalid(tv[0]), .i_m_tready(ready), .o_m_tlast(tl[0]),
        .o_frame_cnt(fc[0]), .o_overrun(ov[0]));
    audio_frame_buffer #(.WL(16), .FFT_N(N), .CH_SEL(CH_MONO)) u_mono (
        .i_clk(clk), .i_rst_n(rst_n), .i_adc_data(adc), .i_rx_done(rx_done), .i_enable(en),
        .o_m_tdata(td[1]), .o_m_tvalid(tv[1]), .i_m_tready(ready), .o_m_tlast(tl[1]),
        .o_frame_cnt(fc[1]), .o_overrun(ov[1]));

    function automatic logic [15:0] mono(input logic [31:0] w);
        int s = $signed(w[31:16]) + $signed(w[15:0]);
        return 16'(s >>> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cap(input logic [31:0] w);
        if (!en) return;
        if (p0.size() == 0 && nfull >= 2) begin m_ovr = 1; return; end
        p0.push_back(w[31:16]);
        p1.push_back(mono(w));
        if (p0.size() == N) begin
            for (int i = 0; i < N; i++) begin q0.push_back(p0[i]); q1.push_back(p1[i]); end
            p0.delete(); p1.delete();
            nfull++;
        end
    endtask

    task automatic cap(input logic [31:0] w, output int lat);
        lat = 0;
        @(posedge clk); #1;
        adc = w; rx_done = 1;
        model_cap(w);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 4) rx_done = 0;
            if (lat == 0 && tv[0]) lat = i;
        end
    endtask

    task automatic set_en(input logic v);
        @(posedge clk); #1;
        en = v;
        if (!v) begin p0.delete(); p1.delete(); end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (q0.size() == 0 && q1.size() == 0 && !tv[0] && !tv[1]) begin done = 1; break; end
        end
        chk("drain_done", 32'(done), 1);
    endtask

    task automatic chk_reset(input string nm);
        for (int d = 0; d < 2; d++)
            chk(nm, {ov[d], tl[d], tv[d], td[d], fc[d][12:0]}, 0);
        chk({nm, "_cnt"}, 32'(fc[0]), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin idx[d] = 0; cnt[d] = 0; gap[d] = 0; stall[d] = 0; end
        end else begin
            for (int d = 0; d < 2; d++) begin
                sz = d ? q1.size() : q0.size();
                chk(d ? "frame_cnt_m" : "frame_cnt_l", 32'(fc[d]), cnt[d]);
                if (gap[d]) chk("frame_gap", 32'(tv[d]), 0);
                if (stall[d]) chk("stall_hold", {tv[d], tl[d], td[d]}, {1'b1, pl[d], pd[d]});
                gap[d] = 0;
                if (tv[d]) begin
                    if (sz == 0) chk("spurious_valid", 32'(tv[d]), 0);
                    else begin
                        hd = d ? q1[0] : q0[0];
                        chk(d ? "data_mono" : "data_left", 32'(td[d]), 32'(hd));
                        chk("tlast", 32'(tl[d]), {31'b0, idx[d] == N - 1});
                        if (ready) begin
                            if (d != 0) begin log1.push_back(td[1]); void'(q1.pop_front()); end
                            else begin log0.push_back(td[0]); void'(q0.pop_front()); end
                            idx[d]++;
                            if (idx[d] == N) begin
                                idx[d] = 0; cnt[d]++; gap[d] = 1;
                                if (d == 0) nfull--;
                            end
                        end
                    end
                end
                stall[d] = tv[d] && !ready;
                pd[d] = td[d];
                pl[d] = tl[d];
            end
        end
    end

    initial begin
        int lat;
        bit hit;
        en = 1;
        #1 rst_n = 0;
        #1 chk_reset("reset_state");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        chk("model_mono_neg", 32'(mono(32'h8000_7FFF)), 32'h0000_FFFF);
        chk("model_mono_pos", 32'(mono(32'h0003_0001)), 32'h0000_0002);
        chk("model_mono_max", 32'(mono(32'h7FFF_7FFF)), 32'h0000_7FFF);

        rdy_fix = 1;
        for (int k = 0; k < N; k++) begin
            cap({16'(k), 16'hAAAA}, lat);
            chk(k == N - 1 ? "stream_latency" : "early_valid__", 32'(lat), k == N - 1 ? 5 : 0);
        end
        drain();
        chk("basic_len", 32'(log0.size()), N);
        for (int i = 0; i < log0.size(); i++) chk("basic_data", 32'(log0[i]), i);
        chk("basic_frame_cnt", 32'(fc[0]), 1);
        chk("basic_overrun", {ov[1], ov[0]}, 0);

        log1.delete();
        cap(32'h8000_7FFF, lat);
        cap(32'h0003_0001, lat);
        cap(32'h7FFF_7FFF, lat);
        for (int k = 3; k < N; k++) cap($urandom, lat);
        drain();
        chk("mono_neg", 32'(log1[0]), 32'hFFFF);
        chk("mono_pos", 32'(log1[1]), 32'h0002);
        chk("mono_max", 32'(log1[2]), 32'h7FFF);

        rnd_rdy = 1;
        for (int k = 0; k < 2 * N; k++) cap($urandom, lat);
        drain();
        rnd_rdy = 0;
        chk("bp_frame_cnt", 32'(fc[0]), 4);

        for (int k = 0; k < 5; k++) cap({16'h1111, 16'(k)}, lat);
        set_en(0);
        cap(32'h5555_5555, lat);
        set_en(1);
        log0.delete();
        for (int k = 0; k < N; k++) cap({16'h0100 + 16'(k), 16'h0001}, lat);
        drain();
        chk("dis_len", 32'(log0.size()), N);
        chk("dis_first", 32'(log0[0]), 32'h0100);
        chk("dis_frame_cnt", 32'(fc[0]), 5);

        @(posedge clk); #1 rdy_fix = 0;
        for (int k = 0; k <= 2 * N; k++) cap({16'h2000 + 16'(k), 16'h0000}, lat);
        chk("ovr_flag_l", 32'(ov[0]), 32'(m_ovr));
        chk("ovr_flag_m", 32'(ov[1]), 1);
        log0.delete();
        @(posedge clk); #1 rdy_fix = 1;
        drain();
        chk("ovr_len", 32'(log0.size()), 2 * N);
        chk("ovr_f0", 32'(log0[0]), 32'h2000);
        chk("ovr_f1", 32'(log0[N]), 32'h2010);
        chk("ovr_end", 32'(log0[2 * N - 1]), 32'h201F);
        chk("ovr_frame_cnt", 32'(fc[0]), 7);

        @(posedge clk); #1 rdy_fix = 0;
        for (int k = 0; k < N; k++) cap({16'h3000 + 16'(k), 16'h0000}, lat);
        @(posedge clk); #1 rdy_fix = 1;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (idx[0] >= 7) begin hit = 1; break; end
        end
        chk("reach_sample7", 32'(hit), 1);
        #1 rst_n = 0;
        #1 chk_reset("reset_mid");
        q0.delete(); q1.delete(); p0.delete(); p1.delete();
        nfull = 0; m_ovr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        log0.delete();
        for (int k = 0; k < N; k++) cap({16'(3 * k + 7), 16'h8000}, lat);
        drain();
        chk("post_rst_len", 32'(log0.size()), N);
        chk("post_rst_first", 32'(log0[0]), 7);
        chk("post_rst_cnt", 32'(fc[0]), 1);
        chk("post_rst_ovr", {ov[1], ov[0]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_frame_buffer.md
# audio_frame_buffer

Collects received audio samples into fixed-length frames for the FFT datapath. Sits directly downstream of the WM8978 control block: it consumes the 32-bit stereo word and the frame-done pulse, reduces each word to one channel, and writes it into a ping-pong buffer. Each completed frame of FFT_N samples is streamed out over a valid/ready interface to the FFT core.

## Interface
- `WL`, 16: sample width. Each channel occupies WL bits of `adc_data`; WL is fixed at 16.
- `FFT_N`, 1024: samples per frame. Must be a power of two, from 16 to 4096.
- `CH_SEL`, 0: channel selection. 0 = left (`adc_data[31:16]`), 1 = right (`adc_data[15:0]`), 2 = mono average.

Ports:
- `clk` in 1: system clock, ≥ 8× `aud_bclk`.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `adc_data` in 32: stereo sample word. Held stable by the upstream block for a whole audio frame.
- `rx_done` in 1: upstream frame-done pulse, in the `aud_bclk` domain.
- `enable` in 1: when high, frames are captured.
- `m_tdata` out WL: frame sample, signed two's complement.
- `m_tvalid` out 1: `m_tdata` is valid.
- `m_tready` in 1: the FFT core accepts the sample.
- `m_tlast` out 1: marks the last sample of a frame.
- `frame_cnt` out 16: count of frames fully streamed out; wraps modulo 2^16.
- `overrun` out 1: sticky sample-drop flag; cleared only by reset.

## Operation
- **rx_done capture**
  - `rx_done` passes through a 2-flop synchronizer, then rising-edge detection.
  - Each detected edge is one capture event. Bit extraction from `adc_data` happens on that event.
- **Channel reduction**
  - CH_SEL=2 computes (L+R)>>>1 on a sign-extended 17-bit sum, using an arithmetic shift.
  - Example: 0x7FFF and 0x7FFF give 0x7FFF; 0x8000 and 0x7FFF give 0xFFFF.
- **Banks**
  - There are two banks, each FFT_N deep.
  - Each bank state is EMPTY, FILLING, FULL or DRAINING.
  - The writer owns at most one bank and the reader owns at most one bank.
- **Writer**
  - On a capture with `enable`=1, the sample is written at `wr_ptr` in the FILLING bank. If no bank is FILLING, the writer claims an EMPTY bank, lowest index first.
  - When `wr_ptr` reaches FFT_N-1 and that sample is written, the bank becomes FULL and `wr_ptr` returns to 0.
- **Overrun**
  - A capture that finds no EMPTY or FILLING bank is dropped and `overrun` is set.
- **Disable**
  - While `enable`=0, captures are ignored.
  - `wr_ptr` is cleared to 0 and the FILLING bank returns to EMPTY, so the partial frame is discarded.
  - A frame that is FULL or DRAINING still streams out completely.
- **Reader FSM** (states RD_IDLE, RD_PRIME, RD_STREAM)
  - RD_IDLE → RD_PRIME when a bank is FULL. With two FULL banks, the oldest goes first. The bank becomes DRAINING and the RAM read of address 0 is issued.
  - RD_PRIME → RD_STREAM after one cycle. `m_tvalid` goes high.
  - In RD_STREAM, a handshake (`m_tvalid`&`m_tready`) advances `rd_ptr`.
  - `m_tlast`=1 exactly when `rd_ptr`=FFT_N-1.
  - A handshake while `m_tlast`=1 does all of the following: bank → EMPTY, `frame_cnt`+1, next state RD_IDLE. If another bank is FULL in that cycle, the next state is RD_PRIME directly.
- **Simultaneous events**
  - A capture and a handshake in the same cycle are both performed.
  - A bank becoming FULL in the same cycle the reader goes idle is picked up the next cycle.

## Timing
- **Reset values**: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `frame_cnt`=0, `overrun`=0, all banks EMPTY, both pointers 0, FSM in RD_IDLE.
- **Reset mid-operation**: outputs return to their reset values immediately (asynchronous). Partial and full frames are discarded.
- **Capture latency**: the RAM write happens 3 `clk` cycles after the `rx_done` rising edge reaches the flops.
- **Stream latency**: a bank that becomes FULL at cycle t produces `m_tvalid`=1 at t+2, with the reader idle.
- **Throughput**: with `m_tready` held high, one sample per cycle, with no bubbles within a frame. This requires a read-ahead/skid stage.
- **Stability under backpressure**: while `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` hold stable.
- **Frame boundaries**: `m_tvalid` drops for at least 1 cycle between frames (the RD_PRIME cycle).

## Structure
- **Package `audio_pkg`**:
  - CH_SEL constants CH_LEFT, CH_RIGHT, CH_MONO.
  - Bank-state encoding.
  - Reader FSM encoding.
  - ADDR_W = $clog2(FFT_N).
- **Sub-module `frame_buffer_ram`**:
  - Simple dual-port, 2·FFT_N × WL.
  - Registered read with 1-cycle latency.
  - Address is {bank, ptr}, so it infers block RAM.

## Test plan
- **Basic frame**: FFT_N=16, CH_SEL=0, 16 captures with `adc_data`={k,16'hAAAA} for k=0..15, `m_tready`=1 → stream 0..15, `m_tlast` only on 15, `frame_cnt`=1, `overrun`=0.
- **Mono average**: CH_SEL=2, L=0x8000, R=0x7FFF → 0xFFFF. L=0x0003, R=0x0001 → 0x0002.
- **Backpressure**: toggle `m_tready` at random → every sample appears exactly once, in order, with `m_tdata` stable while stalled.
- **Overrun**: `m_tready`=0, 33 captures with FFT_N=16 → `overrun`=1, and the first two frames stream intact when `m_tready` is released.
- **Disable mid-frame**: drop `enable` after 5 captures, re-enable, then 16 captures → the frame contains only the post-enable samples.
- **Reset mid-stream**: assert `rst_n`=0 at sample 7 of a stream → `m_tvalid`=0 immediately, `frame_cnt`=0, and normal operation after release.
